// File: rtl/mips_bus_pkg.sv
// ============================================================================
//  Module      : mips_bus_pkg
//  Description : Shared types and constants for the CPU bus arbiter.
//                The arbiter state is encoded so that the state register
//                value is directly the one-hot grant vector
//                (00 = idle, 01 = instruction port, 10 = data port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic [3:0] BE_WORD    = 4'hF;

    // Encoding of the last_grant bit (who completed most recently).
    localparam logic       LAST_I     = 1'b0;
    localparam logic       LAST_D     = 1'b1;

endpackage : mips_bus_pkg

`default_nettype wire

// File: rtl/mips_bus_arb_pick.sv
// ============================================================================
//  Module      : mips_bus_arb_pick
//  Description : Combinational winner select for the bus arbiter.
//                When both ports are pending, round-robin mode picks the
//                port opposite the last completed grant; fixed mode picks D.
//  Ports       : i_pending_i  - instruction port has a request
//                d_pending_i  - data port has a request
//                last_grant_i - LAST_I / LAST_D, most recent completion
//                pick_o       - one-hot winner (GRANT_NONE when nobody asks)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_bus_arb_pick
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       i_pending_i,
    input  logic       d_pending_i,
    input  logic       last_grant_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = GRANT_NONE;
        if (i_pending_i && d_pending_i) begin
            if (ROUND_ROBIN != 0) begin
                pick_o = (last_grant_i == LAST_D) ? GRANT_I : GRANT_D;
            end else begin
                pick_o = GRANT_D;
            end
        end else if (i_pending_i) begin
            pick_o = GRANT_I;
        end else if (d_pending_i) begin
            pick_o = GRANT_D;
        end
    end

endmodule : mips_bus_arb_pick

`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
// ============================================================================
//  Module      : mips_bus_arbiter
//  Description : Shares one Avalon-MM master port between the instruction
//                fetch (read-only) and data load/store requesters. One port
//                is granted at a time; the grant is held until the transfer
//                completes (command high, bus waitrequest low) or the
//                requester drops its command. A stall counter flags a sticky
//                bus_error after TIMEOUT_CYCLES stalled cycles in one grant.
//  Ports       : clk, reset (async, active-low)
//                i_*        - instruction requester (address/read in,
//                             waitrequest/readdata out)
//                d_*        - data requester (address/read/write/writedata/
//                             byteenable in, waitrequest/readdata out)
//                address/read/write/writedata/byteenable - bus command out
//                waitrequest/readdata                    - bus response in
//                grant      - registered one-hot grant (bit0 I, bit1 D)
//                bus_error  - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch requester
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    // data load/store requester
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    // shared bus master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    // status
    output logic [1:0]  grant,
    output logic        bus_error
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_error_q, bus_error_d;

    logic             w_i_pending;
    logic             w_d_pending;
    logic [1:0]       w_pick;

    assign w_i_pending = i_read;
    assign w_d_pending = d_read | d_write;

    mips_bus_arb_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .i_pending_i  (w_i_pending),
        .d_pending_i  (w_d_pending),
        .last_grant_i (last_grant_q),
        .pick_o       (w_pick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_D;
            cnt_q        <= '0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        bus_error_d  = bus_error_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (w_pick == GRANT_I) begin
                    state_d = GNT_I;
                end else if (w_pick == GRANT_D) begin
                    state_d = GNT_D;
                end
            end

            GNT_I: begin
                if (!w_i_pending) begin
                    // Requester withdrew: release without a completion.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!waitrequest) begin
                    last_grant_d = LAST_I;
                    cnt_d        = '0;
                    state_d      = w_d_pending ? GNT_D : IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            GNT_D: begin
                if (!w_d_pending) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!waitrequest) begin
                    last_grant_d = LAST_D;
                    cnt_d        = '0;
                    state_d      = w_i_pending ? GNT_I : IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The flag rises on the edge where the counter reaches the limit;
        // the grant itself is intentionally kept.
        if (cnt_d == CNT_MAX) begin
            bus_error_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command / response mux (purely from registered state, so an
    // asynchronous reset zeroes the bus immediately)
    // ------------------------------------------------------------------
    always_comb begin
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        i_waitrequest = 1'b1;
        i_readdata    = '0;
        d_waitrequest = 1'b1;
        d_readdata    = '0;

        case (state_q)
            GNT_I: begin
                address       = i_address;
                read          = i_read;
                byteenable    = BE_WORD;
                i_waitrequest = waitrequest;
                i_readdata    = readdata;
            end
            GNT_D: begin
                address       = d_address;
                // simultaneous read+write is treated as a write
                read          = d_read & ~d_write;
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                d_readdata    = readdata;
            end
            default: ;
        endcase
    end

    assign grant     = state_q;
    assign bus_error = bus_error_q;

endmodule : mips_bus_arbiter

`default_nettype wire

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Shares the single Avalon memory-mapped master port of the multicycle CPU between two requesters: instruction fetch (I, read-only) and data load/store (D).
- Grants one requester at a time and holds the grant until its transfer completes.
- Forwards the granted requester's command to the bus and returns waitrequest/readdata to it.
- Sits between the CPU core's fetch/memory stages and the external bus.

Parameters:
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, D wins.
TIMEOUT_CYCLES, 1024, stall cycles within one grant before bus_error is set (>=2).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
i_address  input  32  fetch address.
i_read  input  1  fetch request.
i_waitrequest  output  1  stall to fetch requester.
i_readdata  output  32  fetch data.
d_address  input  32  data address.
d_read  input  1  load request.
d_write  input  1  store request.
d_writedata  input  32  store data.
d_byteenable  input  4  store/load byte lanes.
d_waitrequest  output  1  stall to data requester.
d_readdata  output  32  load data.
address  output  32  bus address.
read  output  1  bus read.
write  output  1  bus write.
writedata  output  32  bus write data.
byteenable  output  4  bus byte lanes.
waitrequest  input  1  bus stall.
readdata  input  32  bus read data.
grant  output  2  one-hot: bit0 = I, bit1 = D, 00 = idle.
bus_error  output  1  sticky timeout flag.

Behaviour:
- States: IDLE, GNT_I, GNT_D. A state register plus a last_grant bit (for round-robin) and a timeout counter.
- Reset (reset==0, asynchronous):
  - State is IDLE, last_grant = D, counter = 0, bus_error = 0.
  - Bus outputs: address, read, write, writedata and byteenable are all 0.
  - i_waitrequest = d_waitrequest = 1; readdata outputs = 0.
- A requester is pending when i_read is high, or when d_read or d_write is high.
- If D asserts d_read and d_write together, the transfer is a write and read is masked.
- IDLE:
  - Bus outputs are 0; both waitrequests are 1.
  - On a clock edge with pending requests, move to the winner's GNT state.
  - Both pending: ROUND_ROBIN=1 grants the port opposite last_grant; ROUND_ROBIN=0 grants D.
- GNT_x, with x being the granted port:
  - The bus is driven combinationally from port x. The I port drives byteenable = 4'hF, write = 0, writedata = 0.
  - x_waitrequest follows the bus waitrequest; x_readdata follows the bus readdata. The other port sees waitrequest = 1 and readdata = 0.
- Completion: a cycle in GNT_x with port x's command high and bus waitrequest = 0. On that edge:
  - last_grant becomes x and the counter clears.
  - Next state is GNT_other if the other port is pending, otherwise IDLE.
- Abort: if port x drops its command while granted, return to IDLE at the next edge. No completion occurs and last_grant is unchanged.
- Latency:
  - From IDLE, a request in cycle N appears on the bus in cycle N+1.
  - With zero bus wait, data returns in N+1.
  - The minimum occupancy is 2 cycles per transfer from IDLE; back-to-back alternation is 1 cycle per transfer.
- Timeout:
  - The counter increments each GNT cycle with bus waitrequest = 1 and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, bus_error is set and stays set until reset.
  - The grant is not released.
- grant is registered state (one-hot of GNT_I/GNT_D).
- Reset asserted mid-transfer: bus outputs go to 0 immediately (asynchronous) and the transfer is dropped.

Decomposition:
- Shared package mips_bus_pkg:
  - arb_state_t enum (IDLE, GNT_I, GNT_D).
  - Constants GRANT_NONE = 2'b00, GRANT_I = 2'b01, GRANT_D = 2'b10, BE_WORD = 4'hF.
- One natural sub-module, mips_bus_arb_pick: combinational winner select from (i_pending, d_pending, last_grant, ROUND_ROBIN).
- The command mux stays in the top level.

Test Plan:
- I-only read of 0xBFC00000, waitrequest = 0, readdata = 0x24020005 → read=1 and address=0xBFC00000 in cycle 2; i_readdata = 0x24020005 with i_waitrequest = 0 that cycle; grant = 00 in cycle 3.
- I and D (read 0x1000) both requesting from reset, ROUND_ROBIN=1 → I granted first, then D in the next cycle; with ROUND_ROBIN=0, D is granted first.
- D write 0x2000, writedata 0xDEADBEEF, byteenable 0x3, waitrequest high for 3 cycles → bus holds all fields for 4 cycles; d_waitrequest is high for 3 then low; i_waitrequest stays 1 throughout.
- D asserts read and write together → bus write = 1, read = 0.
- D drops d_read while granted with the bus stalled → IDLE next cycle; then a pending I is granted with I-first order preserved.
- TIMEOUT_CYCLES = 4, waitrequest held high → bus_error rises after 4 stall cycles and stays set after waitrequest falls. Asserting reset low mid-grant zeroes the bus outputs and clears bus_error asynchronously.
